// File: rtl/vga_frame_tone_seq.sv
// Frame-synchronised 16-note melody generator: advances one note every
// NOTE_FRAMES vsync frames and emits a registered square-wave audio bit.
module vga_frame_tone_seq #(
  parameter int NOTE_FRAMES = 8,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       vsync,
  output logic       sound,
  output logic [3:0] note_idx,
  output logic       frame_tick
);

  localparam int FW = (NOTE_FRAMES > 2) ? $clog2(NOTE_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(NOTE_FRAMES - 1);
  // One extra bit so the limit can equal NOTE_FRAMES when GAP_FRAMES is 0.
  localparam logic [FW:0]   GATE_LIMIT = (FW + 1)'(NOTE_FRAMES - GAP_FRAMES);

  logic          vsync_q;
  logic [FW-1:0] frame_cnt;
  logic [15:0]   div_cnt;
  logic          sq;
  logic [15:0]   hp;
  logic          note_adv;
  logic          gate;

  always_comb begin
    hp = '0;
    case (note_idx)
      4'd0:  hp = 16'd24056;
      4'd1:  hp = 16'd19094;
      4'd2:  hp = 16'd16056;
      4'd3:  hp = 16'd12028;
      4'd4:  hp = 16'd16056;
      4'd5:  hp = 16'd19094;
      4'd6:  hp = 16'd24056;
      4'd7:  hp = 16'd0;
      4'd8:  hp = 16'd21432;
      4'd9:  hp = 16'd18022;
      4'd10: hp = 16'd14304;
      4'd11: hp = 16'd12743;
      4'd12: hp = 16'd14304;
      4'd13: hp = 16'd18022;
      4'd14: hp = 16'd21432;
      default: hp = 16'd0;
    endcase
  end

  always_comb begin
    note_adv = frame_tick && (frame_cnt == LAST_FRAME);
    gate     = enable && (hp != 16'd0) && ({1'b0, frame_cnt} < GATE_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      frame_tick <= 1'b0;
      sound      <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync & ~vsync_q;
      sound      <= sq & gate;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      note_idx  <= '0;
    end else if (!enable) begin
      frame_cnt <= '0;
      note_idx  <= '0;
    end else if (frame_tick) begin
      if (note_adv) begin
        frame_cnt <= '0;
        note_idx  <= note_idx + 4'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Note advance outranks a coincident divider terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sq      <= 1'b0;
    end else if (!enable || note_adv || hp == 16'd0) begin
      div_cnt <= '0;
      sq      <= 1'b0;
    end else if (div_cnt == hp - 16'd1) begin
      div_cnt <= '0;
      sq      <= ~sq;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_frame_tone_seq.sv
// Bench for vga_frame_tone_seq: directed scenario with randomized frame
// spacing, every cycle compared against an age-based behavioural model.
module tb_vga_frame_tone_seq;

  localparam int NF = 8;
  localparam int GF = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       vsync = 1'b0;
  logic       sound;
  logic [3:0] note_idx;
  logic       frame_tick;

  vga_frame_tone_seq #(.NOTE_FRAMES(NF), .GAP_FRAMES(GF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
    .sound(sound), .note_idx(note_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned rom [16] = '{24056, 19094, 16056, 12028, 16056, 19094, 24056, 0,
                            21432, 18022, 14304, 12743, 14304, 18022, 21432, 0};

  // Model: tone phase is derived from cycles elapsed since the note started.
  logic        m_vq, m_tick, m_sound;
  int unsigned m_frame, m_note, m_age;

  int tests = 0;
  int fails = 0;
  int unsigned nticks = 0;
  int unsigned hi_cnt = 0;
  int unsigned ft_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vq = 1'b0; m_tick = 1'b0; m_sound = 1'b0;
    m_frame = 0; m_note = 0; m_age = 0;
  endtask

  task automatic model_step();
    int unsigned hp;
    logic sq, gate, n_tick;
    hp     = rom[m_note];
    sq     = (hp != 0) && (((m_age / hp) % 2) == 1);
    gate   = enable && (hp != 0) && (m_frame < NF - GF);
    n_tick = vsync && !m_vq;
    if (!enable) begin
      m_frame = 0; m_note = 0; m_age = 0;
    end else if (m_tick && m_frame == NF - 1) begin
      m_frame = 0; m_note = (m_note + 1) % 16; m_age = 0;
    end else begin
      if (m_tick) m_frame++;
      m_age = (hp != 0) ? m_age + 1 : 0;
    end
    m_sound = sq && gate;
    m_tick  = n_tick;
    m_vq    = vsync;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", {27'd0, sound, note_idx, frame_tick}, {27'd0, m_sound, m_note[3:0], m_tick});
    if (sound === 1'b1) hi_cnt++;
    if (frame_tick === 1'b1) ft_cnt++;
  endtask

  task automatic frame(input int unsigned len);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (len - 1) tick();
    nticks++;
  endtask

  task automatic wait_sound(input logic val, input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sound !== val && n <= limit);
  endtask

  initial begin
    int unsigned n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sound", {31'd0, sound}, 32'd0);
    chk("rst_note", {28'd0, note_idx}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Reach note 1 with a tick in flight, then reset asynchronously
    repeat (NF) frame(4);
    chk("pre_rst_note", {28'd0, note_idx}, 32'd1);
    vsync = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_sound", {31'd0, sound}, 32'd0);
    chk("async_note", {28'd0, note_idx}, 32'd0);
    chk("async_tick", {31'd0, frame_tick}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    vsync  = 1'b0;
    nticks = 0;

    // Note 0 tone timing with no vsync
    wait_sound(1'b1, 30000, n);
    chk("n0_first_rise", n, 32'd24057);
    wait_sound(1'b0, 30000, n);
    chk("n0_high_run", n, 32'd24056);
    chk("n0_note", {28'd0, note_idx}, 32'd0);

    // Advance to note 1, then measure its first half-period
    repeat (NF - 1) frame(16);
    frame(2);
    chk("adv_note1", {28'd0, note_idx}, 32'd1);
    wait_sound(1'b1, 25000, n);
    chk("n1_rise", n, 32'd19095);

    // Gap: with the square held high, the last frame of the note is silent
    hi_cnt = 0;
    repeat (NF) frame(16);
    chk("gap_hi_cycles", hi_cnt, (NF - GF - 1) * 16 + 2);
    chk("adv_note2", {28'd0, note_idx}, 32'd2);

    // Random frame spacing up to the rest note, then to wrap
    while (nticks < 7 * NF) frame($urandom_range(2, 30));
    chk("at_rest", {28'd0, note_idx}, 32'd7);
    hi_cnt = 0;
    repeat (NF) frame($urandom_range(2, 30));
    chk("rest_hi_cycles", hi_cnt, 32'd0);
    while (nticks < 16 * NF) frame($urandom_range(2, 30));
    chk("wrap_note", {28'd0, note_idx}, 32'd0);

    // Long vsync produces a single tick
    ft_cnt = 0;
    vsync  = 1'b1;
    repeat (1000) tick();
    vsync = 1'b0;
    repeat (5) tick();
    chk("long_vsync_ticks", ft_cnt, 32'd1);
    nticks++;

    // Reach note 3, let it go high, then drop enable
    while (nticks < 19 * NF - 1) frame($urandom_range(2, 30));
    frame(2);
    chk("adv_note3", {28'd0, note_idx}, 32'd3);
    wait_sound(1'b1, 13000, n);
    chk("n3_rise", n, 32'd12029);
    enable = 1'b0;
    tick();
    chk("dis_sound", {31'd0, sound}, 32'd0);
    chk("dis_note", {28'd0, note_idx}, 32'd0);
    repeat (20) tick();
    enable = 1'b1;
    repeat (200) tick();

    // Random enable/vsync activity
    repeat (1500) begin
      enable = ($urandom_range(0, 49) != 0);
      vsync  = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_frame_tone_seq.md
Name: vga_frame_tone_seq

Overview:
- Frame-synchronised melody generator sitting downstream of the VGA sync generator, in the same pixel-clock domain.
- Consumes the vsync output of the VGA timing stage and advances through a fixed 16-note melody every NOTE_FRAMES frames.
- Produces a square-wave audio bit on the top level's `sound` net, for routing to a uio pin or an audio PMOD.

Parameters:
- NOTE_FRAMES, 8: frames per note; legal range >=2.
- GAP_FRAMES, 1: trailing silent frames per note (articulation gap); legal range 0..NOTE_FRAMES-1.

Ports:
- clk  input  1  pixel clock, 25.175 MHz nominal.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run/mute control; synchronous.
- vsync  input  1  vertical sync from the timing generator, synchronous to clk, active high.
- sound  output  1  registered square-wave audio.
- note_idx  output  4  current melody index.
- frame_tick  output  1  one-cycle pulse per vsync rising edge.

Behaviour:
- Reset (rst_n low, asynchronous): sound=0, note_idx=0, frame_tick=0. Internal state also clears: vsync_q=0, frame_cnt=0, div_cnt=0, sq=0. Release is synchronous to clk.
- Edge detect:
  - vsync_q <= vsync every cycle.
  - frame_tick <= vsync & ~vsync_q.
  - frame_tick is high for exactly one cycle, in the cycle after the first clk edge that samples vsync=1.
  - vsync held high for any duration yields exactly one tick.
- Melody ROM: half-period in clocks, indexed by note_idx 0..15. Contents: 24056, 19094, 16056, 12028, 16056, 19094, 24056, 0, 21432, 18022, 14304, 12743, 14304, 18022, 21432, 0. A value of 0 means rest.
- Frame/note sequencing, on frame_tick with enable=1:
  - If frame_cnt==NOTE_FRAMES-1: frame_cnt<=0 and note_idx<=note_idx+1 (mod 16; 15 wraps to 0).
  - Otherwise frame_cnt<=frame_cnt+1.
- Enable low:
  - frame_cnt, note_idx, div_cnt and sq are cleared synchronously every cycle; sound=0 next cycle.
  - frame_tick keeps operating.
  - On re-enable, playback restarts at note 0, frame 0.
- Divider, with hp = ROM[note_idx]:
  - If hp==0: div_cnt=0, sq=0.
  - Else if div_cnt==hp-1: div_cnt<=0, sq<=~sq.
  - Else div_cnt<=div_cnt+1.
  - Output period = 2*hp clocks, 50% duty. div_cnt is 16 bits.
- Note change: in the cycle note_idx updates, div_cnt<=0 and sq<=0. The new note always starts from phase 0 with sound low.
- Gate: gate = enable & (hp!=0) & (frame_cnt < NOTE_FRAMES-GAP_FRAMES).
- Output: sound <= sq & gate, registered, so there is 1 cycle of latency from sq to sound.
- Gap handling: the divider keeps running during gap frames; only the output is masked.
- Simultaneous events: frame_tick coinciding with a divider terminal count means the note advance wins (div_cnt<=0, sq<=0).

Test Plan:
- Reset mid-tone: enable=1, note 0 toggling; assert rst_n low between clocks -> sound, note_idx, frame_tick read 0 immediately (asynchronous). After release, the first toggle is 24056 clocks later.
- Tone period: enable=1, no vsync pulses -> sound high/low runs of exactly 24056 clocks each (period 48112); note_idx stays 0.
- Note advance and gap (NOTE_FRAMES=8, GAP_FRAMES=1): 8 short vsync pulses -> sound=0 throughout frame 7; after the 8th frame_tick, note_idx=1 and half-period becomes 19094, starting low.
- Rest and wrap: advance to note_idx=7 -> sound constantly 0 for 8 frames. 128 total frame_ticks -> note_idx back at 0, tone period 48112.
- Long vsync / edge detect: vsync held high 1000 cycles -> frame_tick high exactly 1 cycle; frame_cnt increments by 1.
- Enable drop mid-note (note_idx=3): enable=0 -> sound 0 on the next cycle, note_idx=0. Re-enable -> note 0 tone resumes from phase 0.
